// File: rtl/wb_pkg.sv
// wb_pkg: shared entry type and constants for the write-back buffer.
// Entry widths are fixed here and must match the buffer's DATA_W/ADDR_W.
package wb_pkg;
   localparam int WB_ADDR_W = 5;
   localparam int WB_DATA_W = 32;
   localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-first search of pending entries for one lookup address.
module wb_fwd_match
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  wb_entry_t              i_entries [DEPTH],
   input  logic [PW-1:0]          i_head,
   input  logic [CW-1:0]          i_count,
   input  logic [WB_ADDR_W-1:0]   i_addr,
   output logic                   o_hit,
   output logic [WB_DATA_W-1:0]   o_data
);
   // Walk oldest to youngest so the last match, the youngest, wins.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CW'(k) < i_count && i_addr != REG_ZERO &&
             i_entries[PW'(i_head + PW'(k))].addr == i_addr) begin
            o_hit  = 1'b1;
            o_data = i_entries[PW'(i_head + PW'(k))].data;
         end
      end
   end
endmodule

// File: rtl/wb_buffer.sv
// wb_buffer: in-order write-back queue feeding the register-file write port, with read forwarding.
// Optional WB_BUF_COALESCE_EN merges a push into the youngest entry when the address matches.
module wb_buffer
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        push_valid_i,
   output logic                        push_ready_o,
   input  logic [ADDR_W-1:0]           push_addr_i,
   input  logic [DATA_W-1:0]           push_data_i,
   input  logic                        drain_en_i,
   output logic                        rf_we_o,
   output logic [ADDR_W-1:0]           rf_wa_o,
   output logic [DATA_W-1:0]           rf_wd_o,
   input  logic [ADDR_W-1:0]           ra1_i,
   input  logic [ADDR_W-1:0]           ra2_i,
   output logic                        hit1_o,
   output logic [DATA_W-1:0]           fwd1_o,
   output logic                        hit2_o,
   output logic [DATA_W-1:0]           fwd2_o,
   output logic [$clog2(DEPTH+1)-1:0]  count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t         r_mem [DEPTH];
   logic [PW-1:0]     r_head, r_tail;
   logic [CW-1:0]     r_count;
   logic [PW-1:0]     w_young;
   logic              w_drain, w_coal, w_fire, w_enq;
   logic              w_hit1, w_hit2;
   logic [DATA_W-1:0] w_fwd1, w_fwd2;

   assign w_drain = (r_count != '0) && drain_en_i && !rst_i;
   assign w_young = r_tail - 1'b1;
`ifdef WB_BUF_COALESCE_EN
   // A lone head entry leaving this cycle cannot absorb the push.
   assign w_coal = (r_count != '0) && r_mem[w_young].addr == push_addr_i &&
                   !(r_count == CW'(1) && w_drain);
`else
   assign w_coal = 1'b0;
`endif
   assign push_ready_o = !rst_i && (r_count < CW'(DEPTH) || w_drain || w_coal);
   assign w_fire       = push_valid_i && push_ready_o;
   assign w_enq        = w_fire && push_addr_i != REG_ZERO && !w_coal;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_mem[r_tail] <= '{addr: push_addr_i, data: push_data_i};
            r_tail        <= r_tail + 1'b1;
         end
         if (w_fire && w_coal)
            r_mem[w_young].data <= push_data_i;
         if (w_drain)
            r_head <= r_head + 1'b1;
         r_count <= r_count + CW'(w_enq) - CW'(w_drain);
      end
   end

   assign rf_we_o = w_drain;
   assign rf_wa_o = w_drain ? r_mem[r_head].addr : '0;
   assign rf_wd_o = w_drain ? r_mem[r_head].data : '0;
   assign count_o = r_count;

   wb_fwd_match #(.DEPTH(DEPTH)) u_match1 (
      .i_entries(r_mem), .i_head(r_head), .i_count(r_count), .i_addr(ra1_i),
      .o_hit(w_hit1), .o_data(w_fwd1)
   );
   wb_fwd_match #(.DEPTH(DEPTH)) u_match2 (
      .i_entries(r_mem), .i_head(r_head), .i_count(r_count), .i_addr(ra2_i),
      .o_hit(w_hit2), .o_data(w_fwd2)
   );

   assign hit1_o = w_hit1 && !rst_i;
   assign fwd1_o = rst_i ? '0 : w_fwd1;
   assign hit2_o = w_hit2 && !rst_i;
   assign fwd2_o = rst_i ? '0 : w_fwd2;
endmodule
